// File: rtl/counter_scoreboard_chk_if.sv
// Interface bundling the stimulus, observed-DUT and checker-result signals of
// counter_scoreboard_chk. clk and reset stay outside as plain module ports.
//   master : the testbench side; drives stimulus and dut_* observations,
//            reads the model and error statistics.
//   slave  : the checker side; the mirror image of master.
// Signals:
//   enable, mode, D, check_en      stimulus shared with the counter DUT
//   dut_Q, dut_rco, dut_load       values observed on the counter DUT
//   model_Q, model_rco, model_load expected counter outputs
//   mismatch, mismatch_mask        registered comparison result
//   err_sticky, err_count          error statistics
//   cycle_count                    clock edges since reset
//   first_err_cyc, first_err_mode  context captured at the first mismatch
interface counter_scoreboard_chk_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic             check_en;
  logic [WIDTH-1:0] dut_Q;
  logic             dut_rco;
  logic             dut_load;
  logic [WIDTH-1:0] model_Q;
  logic             model_rco;
  logic             model_load;
  logic             mismatch;
  logic [2:0]       mismatch_mask;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] first_err_cyc;
  logic [1:0]       first_err_mode;

  modport master (
    output enable, mode, D, check_en, dut_Q, dut_rco, dut_load,
    input  model_Q, model_rco, model_load, mismatch, mismatch_mask,
           err_sticky, err_count, cycle_count, first_err_cyc, first_err_mode
  );

  modport slave (
    input  enable, mode, D, check_en, dut_Q, dut_rco, dut_load,
    output model_Q, model_rco, model_load, mismatch, mismatch_mask,
           err_sticky, err_count, cycle_count, first_err_cyc, first_err_mode
  );
endinterface

// File: rtl/counter_scoreboard_chk.sv
// Reference model and self-checker for the multi-mode up/down/load counter.
// Each rising clk edge the model advances exactly as the counter should, and
// (when check_en=1) the DUT's pre-edge Q/rco/load are compared against the
// model's pre-edge values. The result is registered, so mismatch pulses one
// clock after the offending values. Error statistics are kept alongside.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears every register, no compare
//   bus    counter_scoreboard_chk_if.slave (stimulus, DUT observations,
//          model outputs and statistics)
module counter_scoreboard_chk #(
  parameter int WIDTH     = 32,
  parameter int DOWN_STEP = 3,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  counter_scoreboard_chk_if.slave  bus
);

  localparam logic [1:0]       MODE_UP    = 2'b00;
  localparam logic [1:0]       MODE_DOWN1 = 2'b01;
  localparam logic [1:0]       MODE_DOWNN = 2'b10;
  localparam logic [1:0]       MODE_LOAD  = 2'b11;
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(DOWN_STEP);
  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [WIDTH-1:0] q;
  logic             rco;
  logic             load;
  logic [1:0]       mode_prev;   // mode that produced the current q
  logic             mismatch;
  logic [2:0]       mask;
  logic             sticky;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] first_err_cyc;
  logic [1:0]       first_err_mode;

  logic [WIDTH-1:0] q_next;
  logic             rco_next;
  logic             load_next;
  logic [2:0]       diff;

  // Next model state; enable=0 forces the counter back to zero.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    q_next    = '0;
    rco_next  = 1'b0;
    load_next = 1'b0;
    if (bus.enable) begin
      case (bus.mode)
        MODE_UP: begin
          q_next   = q + WIDTH'(1);
          rco_next = (q == ALL_ONES);
        end
        MODE_DOWN1: begin
          q_next   = q - WIDTH'(1);
          rco_next = (q == '0);
        end
        MODE_DOWNN: begin
          q_next   = q - STEP;
          rco_next = (q < STEP);   // borrow out of the multi-step decrement
        end
        MODE_LOAD: begin
          q_next    = bus.D;
          load_next = 1'b1;
        end
        default: begin
          q_next = q;
        end
      endcase
    end
  end

  // Pre-edge comparison, ordered {Q, rco, load}.
  assign diff = {bus.dut_Q != q, bus.dut_rco != rco, bus.dut_load != load};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values (e.g. first_err_cyc takes the old
    // cycle_count, not the incremented one).
    if (reset) begin
      q              <= '0;
      rco            <= 1'b0;
      load           <= 1'b0;
      mode_prev      <= '0;
      mismatch       <= 1'b0;
      mask           <= '0;
      sticky         <= 1'b0;
      err_count      <= '0;
      cycle_count    <= '0;
      first_err_cyc  <= '0;
      first_err_mode <= '0;
    end else begin
      q           <= q_next;
      rco         <= rco_next;
      load        <= load_next;
      mode_prev   <= bus.mode;
      cycle_count <= cycle_count + CNT_W'(1);
      if (bus.check_en) begin
        mismatch <= |diff;
        mask     <= diff;
        if (|diff) begin
          if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
          sticky <= 1'b1;
          // Only the first failure is recorded; later ones never overwrite it.
          if (!sticky) begin
            first_err_cyc  <= cycle_count;
            first_err_mode <= mode_prev;
          end
        end
      end else begin
        mismatch <= 1'b0;   // mask holds its last compared value
      end
    end
  end

  assign bus.model_Q        = q;
  assign bus.model_rco      = rco;
  assign bus.model_load     = load;
  assign bus.mismatch       = mismatch;
  assign bus.mismatch_mask  = mask;
  assign bus.err_sticky     = sticky;
  assign bus.err_count      = err_count;
  assign bus.cycle_count    = cycle_count;
  assign bus.first_err_cyc  = first_err_cyc;
  assign bus.first_err_mode = first_err_mode;

endmodule

// File: tb/tb_counter_scoreboard_chk.sv
// Scoreboard bench for counter_scoreboard_chk (WIDTH=8, DOWN_STEP=3, CNT_W=8).
// The stimulus process plays the counter DUT: it drives dut_* from the values
// it expects the model to hold, optionally corrupted, and pushes the expected
// post-edge outputs into a queue. A monitor pops and compares after each edge.
module tb_counter_scoreboard_chk;
  localparam int WIDTH     = 8;
  localparam int DOWN_STEP = 3;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_scoreboard_chk_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  counter_scoreboard_chk #(
    .WIDTH(WIDTH), .DOWN_STEP(DOWN_STEP), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       rco;
    logic       load;
    logic       mm;
    logic [2:0] mask;
    logic       sticky;
    logic [7:0] errc;
    logic [7:0] fcyc;
    logic [1:0] fmode;
    logic [7:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Expected state as seen by the stimulus side.
  logic [7:0] cur_q, e_errc, e_fcyc, cyc;
  logic       cur_rco, cur_load, e_sticky;
  logic [2:0] e_mask;
  logic [1:0] mprev, e_fmode;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.q = cur_q;  e.rco = cur_rco;  e.load = cur_load;  e.mm = 1'b0;
    e.mask = e_mask;  e.sticky = e_sticky;  e.errc = e_errc;
    e.fcyc = e_fcyc;  e.fmode = e_fmode;  e.cyc = cyc;
    return e;
  endfunction

  // Reset edge with arbitrary other inputs; dut_* carry junk to show that no
  // comparison happens on a reset cycle.
  task automatic do_reset(input logic en, input logic [1:0] md, input logic [7:0] d);
    @(negedge clk);
    reset = 1'b1;  bus.enable = en;  bus.mode = md;  bus.D = d;  bus.check_en = 1'b1;
    bus.dut_Q = 8'hA5;  bus.dut_rco = 1'b1;  bus.dut_load = 1'b1;
    cur_q = '0;  cur_rco = 1'b0;  cur_load = 1'b0;  cyc = '0;  mprev = '0;
    e_errc = '0;  e_fcyc = '0;  e_sticky = 1'b0;  e_mask = '0;  e_fmode = '0;
    sb.push_back(snapshot());
    @(posedge clk);
  endtask

  // One normal edge. *_x corrupt the DUT observation; nq/nrco/nload are the
  // hand-computed model values after the edge.
  task automatic step(input logic en, input logic [1:0] md, input logic [7:0] d,
                      input logic chk, input logic [7:0] q_x, input logic rco_x,
                      input logic load_x, input logic [7:0] nq, input logic nrco,
                      input logic nload);
    logic [2:0] diff;
    logic       mm;
    exp_t       e;
    @(negedge clk);
    reset = 1'b0;  bus.enable = en;  bus.mode = md;  bus.D = d;  bus.check_en = chk;
    bus.dut_Q = cur_q ^ q_x;  bus.dut_rco = cur_rco ^ rco_x;  bus.dut_load = cur_load ^ load_x;
    diff = {q_x != 8'h00, rco_x, load_x};
    mm   = chk && (diff != 3'b000);
    if (chk) e_mask = diff;
    if (mm) begin
      if (!e_sticky) begin
        e_fcyc  = cyc;
        e_fmode = mprev;
      end
      e_sticky = 1'b1;
      if (e_errc != 8'hFF) e_errc = e_errc + 8'd1;
    end
    cyc = cyc + 8'd1;  mprev = md;
    cur_q = nq;  cur_rco = nrco;  cur_load = nload;
    e = snapshot();
    e.mm = mm;
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("model_Q",        bus.model_Q,        e.q);
        check("model_rco",      bus.model_rco,      e.rco);
        check("model_load",     bus.model_load,     e.load);
        check("mismatch",       bus.mismatch,       e.mm);
        check("mismatch_mask",  bus.mismatch_mask,  e.mask);
        check("err_sticky",     bus.err_sticky,     e.sticky);
        check("err_count",      bus.err_count,      e.errc);
        check("first_err_cyc",  bus.first_err_cyc,  e.fcyc);
        check("first_err_mode", bus.first_err_mode, e.fmode);
        check("cycle_count",    bus.cycle_count,    e.cyc);
      end
    end
  end

  initial begin
    logic [7:0] qq;
    reset = 1'b1;  bus.enable = 1'b0;  bus.mode = 2'b00;  bus.D = '0;  bus.check_en = 1'b0;
    bus.dut_Q = '0;  bus.dut_rco = 1'b0;  bus.dut_load = 1'b0;

    // 1: count up through the wrap; rco only on FF->00.
    do_reset(1'b0, 2'b00, 8'h00);
    for (int i = 0; i < 256; i++)
      step(1'b1, 2'b00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'(i + 1), i == 255, 1'b0);
    #2;
    check("t1_final_q", bus.model_Q, 8'h00);
    check("t1_err_count", bus.err_count, 8'h00);

    // 2: load 02, then two steps of -3.
    step(1'b1, 2'b11, 8'h02, 1'b1, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1);
    step(1'b1, 2'b10, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 2'b10, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFC, 1'b0, 1'b0);

    // 3: load 00, decrement to FF, then disable.
    step(1'b1, 2'b11, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 2'b01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
    step(1'b0, 2'b01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 4: rco corrupted at cycle 5 (mode_prev=10), Q corrupted at cycle 9.
    do_reset(1'b1, 2'b00, 8'h00);
    step(1'b1, 2'b00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);  // cyc 0
    step(1'b1, 2'b00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);  // cyc 1
    step(1'b1, 2'b00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);  // cyc 2
    step(1'b1, 2'b00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0);  // cyc 3
    step(1'b1, 2'b10, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);  // cyc 4
    step(1'b1, 2'b00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);  // cyc 5
    step(1'b1, 2'b01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);  // cyc 6
    step(1'b1, 2'b01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);  // cyc 7
    step(1'b1, 2'b01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);  // cyc 8
    step(1'b1, 2'b00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);  // cyc 9
    #2;
    check("t4_mask_q", bus.mismatch_mask, 3'b100);
    check("t4_mm_cyc10", bus.mismatch, 1'b1);
    step(1'b1, 2'b00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);  // cyc 10
    step(1'b1, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);  // cyc 11
    #2;
    check("t4_err_count", bus.err_count, 8'd2);
    check("t4_first_err_cyc", bus.first_err_cyc, 8'd5);
    check("t4_first_err_mode", bus.first_err_mode, 2'b10);

    // 5: Q held wrong for 300 edges -> err_count saturates; then check_en=0.
    qq = 8'h02;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 2'b00, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, qq + 8'd1, qq == 8'hFF, 1'b0);
      qq = qq + 8'd1;
    end
    step(1'b1, 2'b00, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, qq + 8'd1, qq == 8'hFF, 1'b0);
    #2;
    check("t5_err_saturated", bus.err_count, 8'hFF);
    check("t5_mismatch_dropped", bus.mismatch, 1'b0);
    check("t5_first_err_kept", bus.first_err_cyc, 8'd5);

    // 6: reset with enable=1 mode=11 gives zeros and no load pulse.
    do_reset(1'b1, 2'b11, 8'h5A);
    #2;
    check("t6_no_load", bus.model_load, 1'b0);
    check("t6_q_zero", bus.model_Q, 8'h00);
    step(1'b1, 2'b11, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
